// File: rtl/stdout_tx_fifo_if.sv
// ============================================================================
//  stdout_tx_fifo_if : core memory-bus link into the buffered stdout block
//  Rev 1.0
// ============================================================================
`default_nettype none

interface stdout_tx_fifo_if;
   logic [31:0] addr;
   logic        valid;
   logic        write;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (
      output addr,
      output valid,
      output write,
      output wdata,
      input  rdata,
      input  ready
   );

   modport slave (
      input  addr,
      input  valid,
      input  write,
      input  wdata,
      output rdata,
      output ready
   );
endinterface

`default_nettype wire

// File: rtl/stdout_tx_fifo.sv
// ============================================================================
//  stdout_tx_fifo : byte FIFO between core stdout writes and the tty_tx link
//  Rev 1.0
// ============================================================================
`default_nettype none

module stdout_tx_fifo #(
   parameter int          DEPTH     = 16,
   parameter int          AW        = 4,
   parameter logic [31:0] DATA_ADDR = 32'h0000_3000,
   parameter logic [31:0] STAT_ADDR = 32'h0000_3008
) (
   input  logic            clk,
   input  logic            rstb,
   stdout_tx_fifo_if.slave bus,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic [7:0]      tx_data,
   output logic [AW:0]     level,
   output logic            empty,
   output logic            full
);

   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t          state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     level_nxt;
   logic            sel;
   logic            is_data;
   logic            push;
   logic            pop;
   logic            flush;
   logic [31:0]     status_word;
   logic            unused_wdata;

   assign is_data = (bus.addr == DATA_ADDR);
   assign sel     = bus.valid && (is_data || (bus.addr == STAT_ADDR));

   // Push gates on the registered full flag, so a slot freed by a pop is
   // only usable on the following cycle.
   assign push  = (state == IDLE) && sel && bus.write && is_data && !full;
   assign flush = (state == IDLE) && sel && bus.write && !is_data && bus.wdata[0];
   assign pop   = tx_valid && tx_ready;

   assign status_word  = {14'b0, full, empty, 16'(level)};
   assign unused_wdata = ^bus.wdata[31:8];

   assign tx_valid = !empty;
   assign tx_data  = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + (AW + 1)'(1);
      end else if (pop && !push) begin
         level_nxt = level - (AW + 1)'(1);
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.wdata[7:0];
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
         empty <= (level_nxt == '0);
         full  <= (level_nxt == FULL_LEVEL);
      end
   end

   // A data write while full leaves the FSM in IDLE so the held request is retried.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= IDLE;
         bus.ready <= 1'b0;
         bus.rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.ready <= 1'b0;
               if (sel) begin
                  if (bus.write) begin
                     if (!is_data || !full) begin
                        state     <= ACK;
                        bus.ready <= 1'b1;
                     end
                  end else begin
                     bus.rdata <= is_data ? 32'h0 : status_word;
                     state     <= ACK;
                     bus.ready <= 1'b1;
                  end
               end
            end
            ACK: begin
               bus.ready <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               bus.ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stdout_tx_fifo.sv
// ============================================================================
//  tb_stdout_tx_fifo : directed self-checking bench for stdout_tx_fifo
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_stdout_tx_fifo;

   logic       clk;
   logic       rstb;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic [4:0] level;
   logic       empty;
   logic       full;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_q [$];

   stdout_tx_fifo_if bus ();

   stdout_tx_fifo #(
      .DEPTH     (16),
      .AW        (4),
      .DATA_ADDR (32'h0000_3000),
      .STAT_ADDR (32'h0000_3008)
   ) dut (
      .clk      (clk),
      .rstb     (rstb),
      .bus      (bus),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .level    (level),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one bus write, returns at the negedge where ready is seen.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output bit acked);
      acked     = 1'b0;
      bus.addr  = a;
      bus.wdata = d;
      bus.write = 1'b1;
      bus.valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            acked = 1'b1;
            break;
         end
      end
      bus.valid = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output bit acked);
      acked     = 1'b0;
      d         = 32'hDEAD_BEEF;
      bus.addr  = a;
      bus.wdata = 32'h0;
      bus.write = 1'b0;
      bus.valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            acked = 1'b1;
            d     = bus.rdata;
            break;
         end
      end
      bus.valid = 1'b0;
   endtask

   // Drains with tx_ready held high, checking each head byte against exp_q.
   task automatic drain_check();
      int guard = 0;
      tx_ready = 1'b1;
      while (exp_q.size() > 0 && guard < 200) begin
         if (tx_valid) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (tx_data !== e) begin
               n_fail++;
               $display("FAIL drain_byte: got %02h expected %02h", tx_data, e);
            end
         end
         @(negedge clk);
         guard++;
      end
      tx_ready = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_done: left=%0d empty=%b expected left=0 empty=1", exp_q.size(), empty);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rstb      = 1'b0;
      tx_ready  = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      bus.write = 1'b0;
      bus.valid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({level, empty, full, tx_valid, bus.ready} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_flags: level=%0d empty=%b full=%b tx_valid=%b ready=%b expected 0 1 0 0 0",
                  level, empty, full, tx_valid, bus.ready);
      end
      n_cmp++;
      if (bus.rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %08h expected 00000000", bus.rdata);
      end
      rstb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      bit ack;
      tx_ready = 1'b0;
      bus_wr(32'h3000, 32'hFFFF_FF48, ack);
      n_cmp++;
      if (!ack || tx_valid !== 1'b1 || tx_data !== 8'h48 || level !== 5'd1 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL single_push: ack=%b tx_valid=%b tx_data=%02h level=%0d empty=%b expected 1 1 48 1 0",
                  ack, tx_valid, tx_data, level, empty);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready_pulse: ready=%b expected 0", bus.ready);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      n_cmp++;
      if (level !== 5'd0 || empty !== 1'b1 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pop: level=%0d empty=%b tx_valid=%b expected 0 1 0", level, empty, tx_valid);
      end
   endtask

   task automatic test_full_stall();
      bit          ack;
      bit          all_ack = 1'b1;
      bit          stalled = 1'b1;
      logic [31:0] rd;
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus_wr(32'h3000, 32'hA0 + i, ack);
         all_ack &= ack;
         exp_q.push_back(8'(8'hA0 + i));
      end
      n_cmp++;
      if (!all_ack || full !== 1'b1 || level !== 5'd16) begin
         n_fail++;
         $display("FAIL fill_16: all_ack=%b full=%b level=%0d expected 1 1 16", all_ack, full, level);
      end
      bus_rd(32'h3008, rd, ack);
      n_cmp++;
      if (!ack || rd !== 32'h0002_0010) begin
         n_fail++;
         $display("FAIL status_full: ack=%b rdata=%08h expected 00020010", ack, rd);
      end
      bus.addr  = 32'h3000;
      bus.wdata = 32'hB0;
      bus.write = 1'b1;
      bus.valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.ready !== 1'b0) stalled = 1'b0;
      end
      n_cmp++;
      if (!stalled || level !== 5'd16) begin
         n_fail++;
         $display("FAIL stall_17th: stalled=%b level=%0d expected 1 16", stalled, level);
      end
      n_cmp++;
      if (tx_data !== 8'hA0) begin
         n_fail++;
         $display("FAIL head_before_pop: got %02h expected a0", tx_data);
      end
      void'(exp_q.pop_front());
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      n_cmp++;
      if (bus.ready !== 1'b0 || level !== 5'd15) begin
         n_fail++;
         $display("FAIL pop_before_push: ready=%b level=%0d expected 0 15", bus.ready, level);
      end
      ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            ack = 1'b1;
            break;
         end
      end
      bus.valid = 1'b0;
      exp_q.push_back(8'hB0);
      n_cmp++;
      if (!ack || level !== 5'd16 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_17th: ack=%b level=%0d full=%b expected 1 16 1", ack, level, full);
      end
      drain_check();
   endtask

   task automatic test_status_read();
      bit          ack;
      logic [31:0] rd;
      bus_rd(32'h3008, rd, ack);
      n_cmp++;
      if (!ack || rd !== 32'h0001_0000) begin
         n_fail++;
         $display("FAIL status_empty: ack=%b rdata=%08h expected 00010000", ack, rd);
      end
      for (int i = 0; i < 5; i++) bus_wr(32'h3000, 32'h30 + i, ack);
      bus_rd(32'h3008, rd, ack);
      n_cmp++;
      if (!ack || rd !== 32'h0000_0005) begin
         n_fail++;
         $display("FAIL status_level5: ack=%b rdata=%08h expected 00000005", ack, rd);
      end
   endtask

   task automatic test_flush();
      bit ack;
      bus_wr(32'h3000, 32'h35, ack);
      bus_wr(32'h3000, 32'h36, ack);
      n_cmp++;
      if (level !== 5'd7) begin
         n_fail++;
         $display("FAIL flush_setup: level=%0d expected 7", level);
      end
      tx_ready = 1'b1;
      bus_wr(32'h3008, 32'h1, ack);
      tx_ready = 1'b0;
      n_cmp++;
      if (!ack || level !== 5'd0 || empty !== 1'b1 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_with_pop: ack=%b level=%0d empty=%b tx_valid=%b expected 1 0 1 0",
                  ack, level, empty, tx_valid);
      end
   endtask

   task automatic test_data_read_and_ignored();
      bit          ack;
      bit          quiet = 1'b1;
      logic [31:0] rd;
      bus_rd(32'h3008, rd, ack);
      bus_rd(32'h3000, rd, ack);
      n_cmp++;
      if (!ack || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL data_read: ack=%b rdata=%08h expected 00000000", ack, rd);
      end
      bus.addr  = 32'h3004;
      bus.wdata = 32'h55;
      bus.write = 1'b1;
      bus.valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.ready !== 1'b0) quiet = 1'b0;
      end
      bus.valid = 1'b0;
      n_cmp++;
      if (!quiet || level !== 5'd0) begin
         n_fail++;
         $display("FAIL ignored_addr: quiet=%b level=%0d expected 1 0", quiet, level);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] hello [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
      logic [7:0] got [$];
      logic [4:0] max_level = '0;
      bit         all_ack = 1'b1;
      bit         wr_done = 1'b0;
      tx_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               bit ack;
               bus_wr(32'h3000, {24'h0, hello[i]}, ack);
               all_ack &= ack;
            end
            wr_done = 1'b1;
         end
         begin
            int g = 0;
            while (!(wr_done && empty) && g < 200) begin
               @(negedge clk);
               if (level > max_level) max_level = level;
               if (tx_valid) got.push_back(tx_data);
               g++;
            end
         end
      join
      tx_ready = 1'b0;
      n_cmp++;
      if (!all_ack || max_level > 5'd1) begin
         n_fail++;
         $display("FAIL stream_level: all_ack=%b max_level=%0d expected 1 <=1", all_ack, max_level);
      end
      n_cmp++;
      if (got.size() != 6) begin
         n_fail++;
         $display("FAIL stream_count: got %0d bytes expected 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== hello[i]) begin
               n_fail++;
               $display("FAIL stream_byte%0d: got %02h expected %02h", i, got[i], hello[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      bit          ack;
      logic [31:0] rd;
      tx_ready = 1'b0;
      bus_rd(32'h3008, rd, ack);
      for (int i = 0; i < 3; i++) bus_wr(32'h3000, 32'h70 + i, ack);
      bus.addr  = 32'h3000;
      bus.wdata = 32'h73;
      bus.write = 1'b1;
      bus.valid = 1'b1;
      @(negedge clk);
      rstb      = 1'b0;
      bus.valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({level, empty, tx_valid, bus.ready} !== {5'd0, 1'b1, 1'b0, 1'b0} || bus.rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_burst: level=%0d empty=%b tx_valid=%b ready=%b rdata=%08h expected 0 1 0 0 0",
                  level, empty, tx_valid, bus.ready, bus.rdata);
      end
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (level !== 5'd0 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_release: level=%0d tx_valid=%b expected 0 0", level, tx_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_full_stall();
      test_status_read();
      test_flush();
      test_data_read_and_ignored();
      test_back_to_back();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
